load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be: MEM_WORDS, 4, number of 32-bit words in the downstream data memory.
REQ-002 Ports SHALL be: clk  in  1  single clock, all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req_valid  in  1  datapath request strobe.
REQ-005 req_ready  out  1  unit can accept a request.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 rsp_valid  out  1  one-cycle response strobe.
REQ-012 rsp_rdata  out  32  extended load data, 0 for stores.
REQ-013 rsp_err  out  1  misaligned, out-of-range or illegal-size request.
REQ-014 mem_we, mem_a, mem_di  out  1/32/32  data-memory write enable, address and write data.
REQ-015 mem_rd  in  32  data-memory read data, combinational on mem_a.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS, WRITE and RESP; req_ready = 1 only in IDLE.
REQ-017 Handshake: accept when req_valid && req_ready; latch we, size, unsigned, addr and wdata at the accepting edge.
REQ-018 Error check at accept: size 11, half with addr[0] != 0, word with addr[1:0] != 0, or addr[31:2] >= MEM_WORDS; on error go IDLE -> RESP with rsp_err = 1 and no memory access.
REQ-019 mem_a SHALL be {latched addr[31:2], 2'b00}; mem_a SHALL hold its value outside accesses.
REQ-020 Load: ACCESS samples mem_rd, extracts the lane, extends it, registers the result into rsp_rdata, then goes to RESP; rsp_valid comes 2 cycles after accept.
REQ-021 Word store: in ACCESS, mem_we = 1 and mem_di = wdata, then RESP; rsp_valid comes 2 cycles after accept.
REQ-022 Byte/half store (read-modify-write): ACCESS captures mem_rd; in WRITE, mem_we = 1 and mem_di = captured word with the lane replaced, then RESP; rsp_valid comes 3 cycles after accept.
REQ-023 Lane mapping SHALL be little-endian: byte lane = addr[1:0] (bits 8*lane+7..8*lane); half lane = addr[1] (bits 16*addr[1]+15..16*addr[1]).
REQ-024 mem_we SHALL be asserted for exactly one cycle per successful store, never for loads or errored requests.
REQ-025 RESP lasts one cycle with rsp_valid = 1 and has no backpressure; next state is IDLE.
REQ-026 rsp_rdata and rsp_err SHALL hold their values until the next RESP; rsp_err = 0 on successful responses.
REQ-027 req_valid asserted in any state other than IDLE SHALL be ignored; the request is not lost, since req_ready = 0.

Reset
REQ-028 While rst = 1: state = IDLE; mem_we forced to 0 combinationally in that same cycle, including mid-WRITE.
REQ-029 Reset values: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, mem_a = 0, mem_di = 0.
REQ-030 Reset mid-operation SHALL drop the request without a response; a partial RMW SHALL leave memory unmodified.

Structure
REQ-031 Package lsu_pkg SHALL hold the size encoding enum (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-032 Sub-module lsu_align SHALL be purely combinational and perform load lane extraction/extension and store lane merge; the FSM and registers live in load_store_unit.

Verification
REQ-033 Load byte, signed: word1 = 0x8899AABB, load byte signed at addr 0x5 -> rsp_valid at accept+2, rsp_rdata = 0xFFFFFFAA, rsp_err = 0; the same load unsigned -> rsp_rdata = 0x000000AA.
REQ-034 Store half: word2 = 0xDEADBEEF, store half 0x1234 at addr 0xA -> mem_we high exactly one cycle with mem_a = 0x8 and mem_di = 0x1234BEEF; rsp_valid at accept+3.
REQ-035 Misaligned and out-of-range: load word at 0x6 -> rsp_valid at accept+1 with rsp_err = 1 and mem_we never 1; load word at 0x10 with MEM_WORDS = 4 -> rsp_err = 1; size 11 -> rsp_err = 1.
REQ-036 Reset in WRITE: rst asserted during the WRITE of a byte store -> mem_we = 0 that cycle, word unchanged, no rsp_valid, req_ready = 1 on the next cycle.
REQ-037 Back-to-back: req_valid held for two word stores (0x11111111 to 0x0, 0x22222222 to 0x4) -> second accepted only in the cycle after the first RESP, both words written, two rsp_valid pulses.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size and state encodings for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WRITE  = 2'b10,
    RESP   = 2'b11
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane extract/extend for loads and lane merge for stores
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val   = word[{lane, 3'b000} +: 8];
    half_val   = word[{lane[1], 4'b0000} +: 16];
    load_data  = word;
    store_word = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{~is_unsigned & byte_val[7]}}, byte_val};
        store_word = word;
        store_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data  = {{16{~is_unsigned & half_val[15]}}, half_val};
        store_word = word;
        store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = word;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store unit with alignment checks and byte/half read-modify-write
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_di,
  input  logic [31:0] mem_rd
);

  state_e      state, state_n;
  logic        we_q, uns_q;
  size_e       size_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q, rmw_q;
  logic        accept, req_err;
  logic [31:0] load_data, store_word;

  always_comb begin
    req_err = 1'b0;
    if (req_size == SZ_HALF)      req_err = req_addr[0];
    else if (req_size == SZ_WORD) req_err = (req_addr[1:0] != 2'b00);
    else if (req_size != SZ_BYTE) req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) req_err = 1'b1;
  end

  // In WRITE the merge must use the word captured in ACCESS, not the live bus
  lsu_align u_align (
    .word        ((state == WRITE) ? rmw_q : mem_rd),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    mem_we    = 1'b0;
    mem_di    = '0;
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP) && !rst;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_n = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (we_q && size_q != SZ_WORD) begin
          state_n = WRITE;
        end else begin
          state_n = RESP;
          if (we_q) begin
            mem_we = 1'b1;
            mem_di = wdata_q;
          end
        end
      end
      WRITE: begin
        mem_we  = 1'b1;
        mem_di  = store_word;
        state_n = RESP;
      end
      default: state_n = IDLE;
    endcase
    if (rst) begin
      mem_we = 1'b0;
      mem_di = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= SZ_BYTE;
      lane_q    <= 2'b00;
      wdata_q   <= '0;
      rmw_q     <= '0;
      mem_a     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= size_e'(req_size);
        lane_q  <= req_addr[1:0];
        wdata_q <= req_wdata;
        if (req_err) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end else begin
          mem_a <= {req_addr[31:2], 2'b00};
        end
      end
      if (state == ACCESS) rmw_q <= mem_rd;
      if (state_n == RESP && state != IDLE) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= we_q ? 32'h0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized and directed self-checking bench for load_store_unit
module tb_load_store_unit;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, mem_we;
  logic [31:0] rsp_rdata, mem_a, mem_di, mem_rd;

  logic [31:0] mem     [MW];
  logic [31:0] ref_mem [MW];
  logic        tb_we;
  logic [1:0]  tb_idx;
  logic [31:0] tb_val;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_cnt = 0;
  int rsp_cnt = 0;
  logic [31:0] last_a, last_di;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_a        (mem_a),
    .mem_di       (mem_di),
    .mem_rd       (mem_rd)
  );

  assign mem_rd = mem[mem_a[3:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we)     mem[mem_a[3:2]] <= mem_di;
    else if (tb_we) mem[tb_idx] <= tb_val;
  end

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt  <= we_cnt + 1;
      last_a  <= mem_a;
      last_di <= mem_di;
    end
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
    if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
    return (addr / 4) >= MW;
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    if (size == 2'd0) return 32'h0000_00FF;
    if (size == 2'd1) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                           input logic uns, input logic [31:0] addr);
    logic [31:0] v;
    v = (word >> ((addr % 4) * 8)) & size_mask(size);
    if (!uns && size == 2'd0 && v >= 32'h80)   v = v + 32'hFFFF_FF00;
    if (!uns && size == 2'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] size,
                                            input logic [31:0] addr, input logic [31:0] wdata);
    int sh;
    sh = (addr % 4) * 8;
    return (old & ~(size_mask(size) << sh)) | ((wdata & size_mask(size)) << sh);
  endfunction

  task automatic preload(input int idx, input logic [31:0] val);
    tb_we = 1'b1; tb_idx = idx[1:0]; tb_val = val;
    @(posedge clk); #1;
    tb_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic        e;
    int          exp_lat, lat, w0, idx;
    logic [31:0] exp_data;
    e        = ref_err(size, addr);
    idx      = int'(addr / 4);
    exp_lat  = e ? 1 : (we && size != 2'd2) ? 3 : 2;
    exp_data = (e || we) ? 32'h0 : ref_load(ref_mem[idx], size, uns, addr);
    w0       = we_cnt;
    check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " err"}, {31'b0, rsp_err}, {31'b0, e});
    check({tag, " rdata"}, rsp_rdata, exp_data);
    if (we && !e) ref_mem[idx] = ref_store(ref_mem[idx], size, addr, wdata);
    @(posedge clk); #1;
    check({tag, " rdata hold"}, rsp_rdata, exp_data);
    check({tag, " mem_we pulses"}, we_cnt - w0, (we && !e) ? 1 : 0);
    if (!e) check({tag, " mem word"}, mem[idx], ref_mem[idx]);
  endtask

  initial begin
    int acc1, acc2, r0, w0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; tb_we = 1'b0; tb_idx = '0; tb_val = '0;
    @(posedge clk); #1;
    check("reset mem_we", {31'b0, mem_we}, 32'd0);
    for (int i = 0; i < MW; i++) preload(i, $urandom);
    check("reset ready", {31'b0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset rdata", rsp_rdata, 32'd0);
    check("reset err", {31'b0, rsp_err}, 32'd0);
    check("reset mem_a", mem_a, 32'd0);
    check("reset mem_di", mem_di, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    preload(1, 32'h8899_AABB);
    do_req("ldb signed", 1'b0, 2'd0, 1'b0, 32'h5, 32'h0);
    check("ldb signed value", rsp_rdata, 32'hFFFF_FFAA);
    do_req("ldb unsigned", 1'b0, 2'd0, 1'b1, 32'h5, 32'h0);
    check("ldb unsigned value", rsp_rdata, 32'h0000_00AA);

    preload(2, 32'hDEAD_BEEF);
    do_req("sth", 1'b1, 2'd1, 1'b0, 32'hA, 32'h0000_1234);
    check("sth mem_a", last_a, 32'h8);
    check("sth mem_di", last_di, 32'h1234_BEEF);

    do_req("ldw misaligned", 1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
    do_req("ldw range", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req("size11", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0);

    // byte store interrupted by reset during its WRITE cycle
    preload(2, 32'hCAFE_F00D);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h9; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst-write mem_we before", {31'b0, mem_we}, 32'd1);
    r0 = rsp_cnt;
    rst = 1'b1;
    #1;
    check("rst-write mem_we forced", {31'b0, mem_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst-write ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    check("rst-write no rsp", rsp_cnt - r0, 32'd0);
    check("rst-write word kept", mem[2], 32'hCAFE_F00D);

    // two word stores with req_valid held throughout
    r0 = rsp_cnt; w0 = we_cnt; acc1 = -100; acc2 = -200;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h0; req_wdata = 32'h1111_1111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready) begin acc1 = cyc; break; end
    end
    @(posedge clk); #1;
    req_addr = 32'h4; req_wdata = 32'h2222_2222;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready) begin acc2 = cyc; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b2b accept spacing", acc2 - acc1, 32'd3);
    check("b2b rsp pulses", rsp_cnt - r0, 32'd2);
    check("b2b mem_we pulses", we_cnt - w0, 32'd2);
    check("b2b word0", mem[0], 32'h1111_1111);
    check("b2b word1", mem[1], 32'h2222_2222);
    ref_mem[0] = 32'h1111_1111;
    ref_mem[1] = 32'h2222_2222;
    ref_mem[2] = 32'hCAFE_F00D;

    for (int i = 0; i < 60; i++) begin
      do_req("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 19)), $urandom);
    end
    for (int i = 0; i < MW; i++) check("final mem", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
